// File: rtl/clock_pkg.sv
// Shared definitions for the countdown timer: state encoding, BCD limits and
// the preset validity check.
package clock_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StPause   = 2'd2,
    StExpired = 2'd3
  } state_e;

  localparam int unsigned BCD_TIME_W = 24;
  localparam logic [BCD_TIME_W-1:0] BCD_ZERO = 24'h000000;
  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  // Digit order is {H1,H0,M1,M0,S1,S0}; the tens of minutes and seconds stop at 5.
  function automatic logic bcd_time_valid(logic [BCD_TIME_W-1:0] t);
    logic ok;
    ok = (t != BCD_ZERO);
    for (int i = 0; i < 6; i++) begin
      if (t[4*i +: 4] > DIGIT_MAX) ok = 1'b0;
    end
    if (t[7:4] > SEC_TENS_MAX || t[15:12] > SEC_TENS_MAX) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_hms_dec.sv
// Combinational one-second decrement of an HH:MM:SS BCD word, with a flag for
// the final second.
module bcd_hms_dec
  import clock_pkg::*;
(
  input  logic [BCD_TIME_W-1:0] in_i,
  output logic [BCD_TIME_W-1:0] out_o,
  output logic                  is_one_o
);

  logic       borrow;
  logic [3:0] dig;
  logic [3:0] dig_max;

  always_comb begin
    out_o   = in_i;
    borrow  = 1'b1;
    dig     = 4'd0;
    dig_max = DIGIT_MAX;
    for (int i = 0; i < 6; i++) begin
      dig     = in_i[4*i +: 4];
      dig_max = (i == 1 || i == 3) ? SEC_TENS_MAX : DIGIT_MAX;
      if (borrow) begin
        if (dig == 4'd0) begin
          out_o[4*i +: 4] = dig_max;
        end else begin
          out_o[4*i +: 4] = dig - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  assign is_one_o = (in_i == 24'h000001);

endmodule

// File: rtl/countdown_timer.sv
// Kitchen countdown timer: preset register, one-second divider and a
// four-state control FSM driving a BCD HH:MM:SS count.
module countdown_timer
  import clock_pkg::*;
#(
  parameter int unsigned            CLK_HZ         = 50_000_000,
  parameter logic [BCD_TIME_W-1:0]  PRESET_DEFAULT = 24'h000100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [BCD_TIME_W-1:0] preset_value,
  input  logic                  preset_load,
  input  logic                  start_pause,
  input  logic                  clear,
  output logic [BCD_TIME_W-1:0] timer_display,
  output logic                  running,
  output logic                  expired
);

  localparam int unsigned    DivW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(CLK_HZ - 1);

  state_e                  state_q, state_d;
  logic [BCD_TIME_W-1:0]   preset_q, preset_d;
  logic [BCD_TIME_W-1:0]   count_q, count_d;
  logic [DivW-1:0]         div_q, div_d;
  logic [BCD_TIME_W-1:0]   count_dec;
  logic                    count_is_one;
  logic                    load_ok;

  bcd_hms_dec u_dec (
    .in_i     (count_q),
    .out_o    (count_dec),
    .is_one_o (count_is_one)
  );

  assign load_ok = preset_load && bcd_time_valid(preset_value) &&
                   (state_q == StIdle || state_q == StPause);

  always_comb begin
    state_d  = state_q;
    preset_d = preset_q;
    count_d  = count_q;
    div_d    = div_q;
    if (clear) begin
      state_d = StIdle;
      count_d = preset_q;
      div_d   = '0;
    end else if (load_ok) begin
      state_d  = StIdle;
      preset_d = preset_value;
      count_d  = preset_value;
      div_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_pause) begin
            state_d = StRun;
            div_d   = '0;
          end
        end
        StRun: begin
          if (start_pause) begin
            state_d = StPause;
          end else if (div_q == DivMax) begin
            div_d   = '0;
            count_d = count_dec;
            // The last tick lands on zero and parks the timer.
            if (count_is_one) state_d = StExpired;
          end else begin
            div_d = div_q + 1'b1;
          end
        end
        StPause: begin
          if (start_pause) state_d = StRun;
        end
        StExpired: begin
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      preset_q <= PRESET_DEFAULT;
      count_q  <= PRESET_DEFAULT;
      div_q    <= '0;
    end else begin
      state_q  <= state_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      div_q    <= div_d;
    end
  end

  assign timer_display = count_q;
  assign running       = (state_q == StRun);
  assign expired       = (state_q == StExpired);

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer with a seconds-based reference model.
module tb_countdown_timer;

  localparam int unsigned CLK = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] preset_value = 24'h0;
  logic        preset_load = 1'b0;
  logic        start_pause = 1'b0;
  logic        clear = 1'b0;
  logic [23:0] timer_display;
  logic        running;
  logic        expired;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: 0 idle, 1 run, 2 pause, 3 expired; time kept in seconds.
  int m_state, m_preset, m_secs, m_phase;

  countdown_timer #(
    .CLK_HZ         (CLK),
    .PRESET_DEFAULT (24'h000100)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .preset_value  (preset_value),
    .preset_load   (preset_load),
    .start_pause   (start_pause),
    .clear         (clear),
    .timer_display (timer_display),
    .running       (running),
    .expired       (expired)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] to_bcd(input int s);
    int h, m, sc;
    h  = s / 3600;
    m  = (s / 60) % 60;
    sc = s % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(sc / 10), 4'(sc % 10)};
  endfunction

  function automatic int bcd_digit(input logic [23:0] v, input int i);
    logic [23:0] t;
    t = v >> (4 * i);
    return int'(t[3:0]);
  endfunction

  function automatic bit bcd_ok(input logic [23:0] v);
    bit ok;
    ok = (v != 24'h0);
    for (int i = 0; i < 6; i++) if (bcd_digit(v, i) > 9) ok = 0;
    if (bcd_digit(v, 1) > 5 || bcd_digit(v, 3) > 5) ok = 0;
    return ok;
  endfunction

  function automatic int to_secs(input logic [23:0] v);
    return (bcd_digit(v, 5) * 10 + bcd_digit(v, 4)) * 3600 +
           (bcd_digit(v, 3) * 10 + bcd_digit(v, 2)) * 60 +
            bcd_digit(v, 1) * 10 + bcd_digit(v, 0);
  endfunction

  function automatic logic [23:0] m_disp();
    return (m_state == 3) ? 24'h0 : to_bcd(m_secs);
  endfunction

  task automatic model_reset();
    m_state  = 0;
    m_preset = 60;
    m_secs   = 60;
    m_phase  = 0;
  endtask

  task automatic model_step(input logic c, input logic l, input logic [23:0] v, input logic s);
    if (c) begin
      m_state = 0; m_secs = m_preset; m_phase = 0;
    end else if (l && (m_state == 0 || m_state == 2) && bcd_ok(v)) begin
      m_state = 0; m_preset = to_secs(v); m_secs = m_preset; m_phase = 0;
    end else if (s) begin
      if (m_state == 0) begin m_state = 1; m_phase = 0; end
      else if (m_state == 1) m_state = 2;
      else if (m_state == 2) m_state = 1;
    end else if (m_state == 1) begin
      m_phase++;
      if (m_phase == CLK) begin
        m_phase = 0;
        m_secs--;
        if (m_secs == 0) m_state = 3;
      end
    end
  endtask

  task automatic cycle(input logic c, input logic l, input logic [23:0] v, input logic s);
    clear = c; preset_load = l; preset_value = v; start_pause = s;
    @(posedge clk);
    model_step(c, l, v, s);
    #1;
    clear = 1'b0; preset_load = 1'b0; start_pause = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (timer_display !== 24'h000100 || running !== 1'b0 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: disp=%h run=%b exp=%b want 000100/0/0",
               timer_display, running, expired);
    end
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    idle_cycles(6);
    n_tests++;
    if (running !== 1'b1 || timer_display !== 24'h000059) begin
      n_fail++;
      $display("FAIL pre_reset_run: disp=%h run=%b want 000059/1", timer_display, running);
    end
    rst_n = 1'b0;
    model_reset();
    #2;
    n_tests++;
    if (timer_display !== 24'h000100 || running !== 1'b0 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: disp=%h run=%b exp=%b want 000100/0/0",
               timer_display, running, expired);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_expire();
    logic [23:0] want;
    cycle(1'b0, 1'b1, 24'h000005, 1'b0);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    for (int k = 1; k <= 20; k++) begin
      cycle(1'b0, 1'b0, 24'h0, 1'b0);
      want = (k < 20) ? 24'(5 - k / 4) : 24'h0;
      n_tests++;
      if (timer_display !== want || expired !== (k == 20) || running !== (k < 20)) begin
        n_fail++;
        $display("FAIL expire_seq k=%0d: disp=%h exp=%b run=%b want %h/%b/%b",
                 k, timer_display, expired, running, want, k == 20, k < 20);
      end
    end
    cycle(1'b1, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic test_borrow();
    logic [23:0] ins  [2];
    logic [23:0] outs [2];
    ins[0] = 24'h010000; outs[0] = 24'h005959;
    ins[1] = 24'h001000; outs[1] = 24'h000959;
    for (int i = 0; i < 2; i++) begin
      cycle(1'b0, 1'b1, ins[i], 1'b0);
      cycle(1'b0, 1'b0, 24'h0, 1'b1);
      idle_cycles(4);
      n_tests++;
      if (timer_display !== outs[i] || timer_display !== m_disp()) begin
        n_fail++;
        $display("FAIL borrow %h: disp=%h want %h", ins[i], timer_display, outs[i]);
      end
      cycle(1'b1, 1'b0, 24'h0, 1'b0);
    end
  endtask

  task automatic test_pause();
    cycle(1'b0, 1'b1, 24'h000003, 1'b0);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    idle_cycles(2);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b0, 24'h0, 1'b0);
      n_tests++;
      if (timer_display !== 24'h000003 || running !== 1'b0 || expired !== 1'b0) begin
        n_fail++;
        $display("FAIL pause_hold %0d: disp=%h run=%b want 000003/0", i, timer_display, running);
      end
    end
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    cycle(1'b0, 1'b0, 24'h0, 1'b0);
    n_tests++;
    if (timer_display !== 24'h000003 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL resume_early: disp=%h run=%b want 000003/1", timer_display, running);
    end
    cycle(1'b0, 1'b0, 24'h0, 1'b0);
    n_tests++;
    if (timer_display !== 24'h000002) begin
      n_fail++;
      $display("FAIL resume_tick: disp=%h want 000002", timer_display);
    end
    cycle(1'b1, 1'b0, 24'h0, 1'b0);
  endtask

  task automatic test_rejects();
    logic [23:0] bad [3];
    bad[0] = 24'h000060; bad[1] = 24'h00A000; bad[2] = 24'h000000;
    cycle(1'b0, 1'b1, 24'h000007, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, bad[i], 1'b0);
      cycle(1'b1, 1'b0, 24'h0, 1'b0);
      n_tests++;
      if (timer_display !== 24'h000007) begin
        n_fail++;
        $display("FAIL reject %h: disp=%h want 000007", bad[i], timer_display);
      end
    end
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    cycle(1'b0, 1'b1, 24'h000042, 1'b0);
    n_tests++;
    if (timer_display !== 24'h000007 || running !== 1'b1) begin
      n_fail++;
      $display("FAIL load_in_run: disp=%h run=%b want 000007/1", timer_display, running);
    end
    cycle(1'b1, 1'b0, 24'h0, 1'b0);
    n_tests++;
    if (timer_display !== 24'h000007) begin
      n_fail++;
      $display("FAIL load_in_run_preset: disp=%h want 000007", timer_display);
    end
    cycle(1'b0, 1'b1, 24'h000001, 1'b0);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    idle_cycles(4);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    idle_cycles(6);
    n_tests++;
    if (expired !== 1'b1 || running !== 1'b0 || timer_display !== 24'h0) begin
      n_fail++;
      $display("FAIL sp_in_expired: disp=%h exp=%b run=%b want 000000/1/0",
               timer_display, expired, running);
    end
    cycle(1'b0, 1'b1, 24'h000009, 1'b0);
    n_tests++;
    if (expired !== 1'b1 || timer_display !== 24'h0) begin
      n_fail++;
      $display("FAIL load_in_expired: disp=%h exp=%b want 000000/1", timer_display, expired);
    end
    cycle(1'b1, 1'b0, 24'h0, 1'b0);
    n_tests++;
    if (expired !== 1'b0 || timer_display !== 24'h000001) begin
      n_fail++;
      $display("FAIL clear_expired: disp=%h exp=%b want 000001/0", timer_display, expired);
    end
  endtask

  task automatic test_simultaneous();
    bit seen_exp;
    seen_exp = 0;
    cycle(1'b0, 1'b1, 24'h000002, 1'b0);
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cycle(1'b0, 1'b0, 24'h0, 1'b0);
      if (expired === 1'b1) seen_exp = 1;
    end
    cycle(1'b1, 1'b0, 24'h0, 1'b0);
    if (expired === 1'b1) seen_exp = 1;
    n_tests++;
    if (seen_exp || running !== 1'b0 || timer_display !== 24'h000002) begin
      n_fail++;
      $display("FAIL clear_final_tick: disp=%h run=%b seen_exp=%0d want 000002/0/0",
               timer_display, running, seen_exp);
    end
    cycle(1'b0, 1'b0, 24'h0, 1'b1);
    idle_cycles(5);
    cycle(1'b1, 1'b1, 24'h000033, 1'b1);
    idle_cycles(2);
    n_tests++;
    if (timer_display !== 24'h000002 || running !== 1'b0 || expired !== 1'b0) begin
      n_fail++;
      $display("FAIL all_pulses: disp=%h run=%b exp=%b want 000002/0/0",
               timer_display, running, expired);
    end
  endtask

  task automatic test_random();
    logic [23:0] v;
    logic        c, l, s;
    int          pick;
    for (int i = 0; i < 3000; i++) begin
      c = ($urandom_range(0, 39) == 0);
      l = ($urandom_range(0, 14) == 0);
      s = ($urandom_range(0, 9) == 0);
      pick = $urandom_range(0, 3);
      if (pick < 2)       v = to_bcd($urandom_range(1, 9));
      else if (pick == 2) v = 24'($urandom);
      else                v = to_bcd($urandom_range(1, 359999));
      // Invalid loads alongside start_pause have no single reading; keep them apart.
      if (l && !bcd_ok(v)) s = 1'b0;
      cycle(c, l, v, s);
      n_tests++;
      if (timer_display !== m_disp() || running !== (m_state == 1) ||
          expired !== (m_state == 3)) begin
        n_fail++;
        $display("FAIL random cyc=%0d: disp=%h run=%b exp=%b want %h/%b/%b",
                 i, timer_display, running, expired, m_disp(), m_state == 1, m_state == 3);
      end
    end
  endtask

  initial begin
    test_reset();
    test_expire();
    test_borrow();
    test_pause();
    test_rejects();
    test_simultaneous();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
